mm_mult_arbiter: RTL and testbench
==================================

// Module: mm_mult_arbiter
// PURPOSE
//  Shares one pipelined Multiplier (instantiated inside) among NUM_REQ requesters in the mm datapath.
//  Grants are round-robin and burst-locked: a requester keeps the multiplier until it issues an operand pair with LAST.
//  A tag pipeline tracks the owner of each in-flight product. Each result is returned with a one-hot tag.
//  The block sits between the mm_main-style compute FSMs and the multiplier core.
// PARAMETERS
//  W_D        32  operand width; product width is 2*W_D
//  NUM_REQ    4   number of requesters (2..8)
//  MULT_DEPTH 6   DEPTH of the internal Multiplier; its enable->valid latency is MULT_DEPTH+1
// PORTS
//  CLK        in   1            clock
//  RST_N      in   1            synchronous reset, active low
//  HOLD       in   1            1 = issue no new grants; in-flight ops still drain
//  REQ_VALID  in   NUM_REQ      requester i has an operand pair
//  REQ_LAST   in   NUM_REQ      pair is the last of requester i's burst
//  REQ_A      in   NUM_REQ*W_D  operand A, slice i = [i*W_D +: W_D]
//  REQ_B      in   NUM_REQ*W_D  operand B, same slicing
//  REQ_READY  out  NUM_REQ      pair accepted this cycle when VALID&READY
//  RSLT_VALID out  NUM_REQ      one-hot owner of RSLT this cycle
//  RSLT       out  2*W_D        product, passed unchanged from the Multiplier rslt
//  RSLT_LAST  out  1            RSLT belongs to a LAST pair
//  BUSY       out  1            any op accepted but not yet returned, or a burst is open
// BEHAVIOUR
//  Reset (RST_N==0 at posedge):
//   - state=IDLE, rr_ptr=0, tag pipe cleared, mult_enable=0.
//   - RSLT_VALID=0, RSLT_LAST=0, BUSY=0; RSLT is don't-care.
//   - REQ_READY is forced 0 while RST_N==0.
//   - The Multiplier gets RST = ~RST_N. Ops in flight at reset never produce RSLT_VALID.
//  FSM states: IDLE, BURST (owner register holds requester index).
//   - IDLE, HOLD=0: winner = first i with REQ_VALID[i] scanning rr_ptr, rr_ptr+1, ... (mod NUM_REQ).
//     REQ_READY[winner]=1 combinationally; all others 0.
//     On accept: if REQ_LAST[winner], stay IDLE and set rr_ptr=winner+1 (mod NUM_REQ).
//     Otherwise go to BURST with owner=winner.
//   - BURST, HOLD=0: REQ_READY[owner]=REQ_VALID-independent 1; all others 0.
//     Accept with LAST -> IDLE, rr_ptr=owner+1 (mod). Gaps (owner VALID=0) keep BURST.
//   - HOLD=1 in either state: REQ_READY=0 and the state is unchanged.
//  Issue: on accept at cycle t, the block registers A, B, mult_enable=1 and tag {owner, LAST} at t+1.
//   - At most one accept per cycle. The pipeline never stalls: one issue per cycle is sustainable.
//  Return: tag delay line of MULT_DEPTH+1 stages aligned to the Multiplier valid.
//   - RSLT_VALID[tag]=1 with RSLT and RSLT_LAST exactly MULT_DEPTH+2 cycles after accept (8 at defaults).
//   - Consumers must take RSLT that cycle; there is no backpressure.
//  Ordering: results return in accept order; per-requester order is preserved.
//  BUSY = (state==BURST) | (in-flight counter != 0).
//   - Counter: +1 on accept, -1 on RSLT_VALID, net 0 when both happen. Width clog2(MULT_DEPTH+3).
//  Widths: operands are not modified; RSLT is the full 2*W_D product. Sign handling is owned by the Multiplier.
//  rr_ptr wrap: NUM_REQ-1 -> 0. A single valid requester with LAST on every pair gets every cycle.
// TESTING
//  T1 reset: hold RST_N=0 with all REQ_VALID=1 -> REQ_READY=0, RSLT_VALID=0, BUSY=0 for every cycle.
//  T2 single op: req0 A=3 B=5 LAST=1 accepted at t -> RSLT_VALID=4'b0001, RSLT=15, RSLT_LAST=1 at t+8; BUSY falls at t+9.
//  T3 round robin: all 4 VALID, every LAST=1, A=i+1 B=10
//     -> grants 0,1,2,3,0 on consecutive cycles; results 10,20,30,40 with one-hot tags in order.
//  T4 burst lock: req1 sends 4 pairs (LAST on the 4th) while req2 is VALID
//     -> req2 READY=0 until req1's LAST is accepted, then req2 is granted the next cycle.
//  T5 HOLD: assert HOLD mid-burst for 3 cycles
//     -> no accepts, state stays BURST; results already in flight still return on schedule.
//  T6 reset mid-flight: 5 ops in flight, pulse RST_N=0 for 1 cycle
//     -> no RSLT_VALID afterwards, rr_ptr=0, BUSY=0, a fresh req3 op returns 8 cycles after accept.

Source files
------------

// File: rtl/mm_mult_arbiter.sv
// Round-robin, burst-locked arbiter that shares one pipelined Multiplier among NUM_REQ requesters.
// Each product returns exactly MULT_DEPTH+2 cycles after accept, carrying a one-hot owner tag.

module Multiplier #(
  parameter int W_D   = 32,
  parameter int DEPTH = 6
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             enable,
  input  logic [W_D-1:0]   a,
  input  logic [W_D-1:0]   b,
  output logic [2*W_D-1:0] rslt,
  output logic             valid
);
  logic [2*W_D-1:0] prod [DEPTH+1];
  logic [DEPTH:0]   vld;

  always_ff @(posedge CLK) begin
    if (RST) vld <= '0;
    else     vld <= {vld[DEPTH-1:0], enable};
  end

  // Data stages carry no reset; only the valid chain decides what is real.
  always_ff @(posedge CLK) begin
    prod[0] <= {{W_D{1'b0}}, a} * {{W_D{1'b0}}, b};
    for (int k = 1; k <= DEPTH; k++) prod[k] <= prod[k-1];
  end

  assign rslt  = prod[DEPTH];
  assign valid = vld[DEPTH];
endmodule

module mm_mult_arbiter #(
  parameter int W_D        = 32,
  parameter int NUM_REQ    = 4,
  parameter int MULT_DEPTH = 6
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   HOLD,
  input  logic [NUM_REQ-1:0]     REQ_VALID,
  input  logic [NUM_REQ-1:0]     REQ_LAST,
  input  logic [NUM_REQ*W_D-1:0] REQ_A,
  input  logic [NUM_REQ*W_D-1:0] REQ_B,
  output logic [NUM_REQ-1:0]     REQ_READY,
  output logic [NUM_REQ-1:0]     RSLT_VALID,
  output logic [2*W_D-1:0]       RSLT,
  output logic                   RSLT_LAST,
  output logic                   BUSY
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(MULT_DEPTH + 3);
  localparam int NS = MULT_DEPTH + 1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] owner, owner_nxt, rr_ptr, rr_ptr_nxt;
  logic [PW-1:0] grant_idx, scan_idx;
  logic [PW:0]   scan_sum;
  logic          found, accept;

  logic [W_D-1:0] req_a_arr [NUM_REQ];
  logic [W_D-1:0] req_b_arr [NUM_REQ];

  logic [W_D-1:0] a_reg, b_reg;
  logic           mult_en;
  logic [PW-1:0]  issue_owner;
  logic           issue_last;

  logic [PW-1:0]  owner_pipe [NS];
  logic [NS-1:0]  last_pipe, tvld_pipe;

  logic [2*W_D-1:0] mult_rslt;
  logic             mult_valid, mult_rst, fire;
  logic [CW-1:0]    inflight;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] x);
    return (x == PW'(NUM_REQ - 1)) ? '0 : x + 1'b1;
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a_arr[i] = REQ_A[i*W_D +: W_D];
      req_b_arr[i] = REQ_B[i*W_D +: W_D];
    end
  end

  // Grant selection: IDLE scans from rr_ptr for the first valid requester; BURST pins the owner.
  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    rr_ptr_nxt = rr_ptr;
    grant_idx  = owner;
    found      = 1'b0;
    scan_sum   = '0;
    scan_idx   = '0;
    REQ_READY  = '0;
    if (RST_N && !HOLD) begin
      if (state == IDLE) begin
        for (int off = 0; off < NUM_REQ; off++) begin
          scan_sum = {1'b0, rr_ptr} + (PW+1)'(off);
          if (scan_sum >= (PW+1)'(NUM_REQ)) scan_sum = scan_sum - (PW+1)'(NUM_REQ);
          scan_idx = scan_sum[PW-1:0];
          if (!found && REQ_VALID[scan_idx]) begin
            found     = 1'b1;
            grant_idx = scan_idx;
          end
        end
        if (found) REQ_READY[grant_idx] = 1'b1;
      end else begin
        REQ_READY[owner] = 1'b1;
      end
    end
    accept = |(REQ_READY & REQ_VALID);
    if (accept) begin
      if (REQ_LAST[grant_idx]) begin
        state_nxt  = IDLE;
        rr_ptr_nxt = wrap_inc(grant_idx);
      end else begin
        state_nxt = BURST;
        owner_nxt = grant_idx;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state       <= IDLE;
      owner       <= '0;
      rr_ptr      <= '0;
      mult_en     <= 1'b0;
      issue_owner <= '0;
      issue_last  <= 1'b0;
      inflight    <= '0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      rr_ptr   <= rr_ptr_nxt;
      mult_en  <= accept;
      inflight <= inflight + CW'(accept) - CW'(fire);
      if (accept) begin
        a_reg       <= req_a_arr[grant_idx];
        b_reg       <= req_b_arr[grant_idx];
        issue_owner <= grant_idx;
        issue_last  <= REQ_LAST[grant_idx];
      end
    end
  end

  // Tag delay line mirrors the Multiplier's stage count so each tag lines up with its product.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      tvld_pipe <= '0;
      last_pipe <= '0;
      for (int k = 0; k < NS; k++) owner_pipe[k] <= '0;
    end else begin
      tvld_pipe     <= {tvld_pipe[NS-2:0], mult_en};
      last_pipe     <= {last_pipe[NS-2:0], issue_last};
      owner_pipe[0] <= issue_owner;
      for (int k = 1; k < NS; k++) owner_pipe[k] <= owner_pipe[k-1];
    end
  end

  assign mult_rst = ~RST_N;

  Multiplier #(.W_D(W_D), .DEPTH(MULT_DEPTH)) u_mult (
    .CLK    (CLK),
    .RST    (mult_rst),
    .enable (mult_en),
    .a      (a_reg),
    .b      (b_reg),
    .rslt   (mult_rslt),
    .valid  (mult_valid)
  );

  assign fire       = RST_N & mult_valid & tvld_pipe[NS-1];
  assign RSLT       = mult_rslt;
  assign RSLT_LAST  = fire & last_pipe[NS-1];
  assign RSLT_VALID = fire ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << owner_pipe[NS-1]) : '0;
  assign BUSY       = RST_N & ((state == BURST) | (inflight != '0));
endmodule

// File: tb/tb_mm_mult_arbiter.sv
// Randomized scoreboard bench for mm_mult_arbiter: a request-level arbitration model predicts
// grants and queues expected products; a separate monitor checks each returned result.

module tb_mm_mult_arbiter;
  localparam int NR  = 4;
  localparam int W   = 32;
  localparam int LAT = 8;

  logic            CLK = 1'b0;
  logic            RST_N;
  logic            HOLD;
  logic [NR-1:0]   REQ_VALID;
  logic [NR-1:0]   REQ_LAST;
  logic [NR*W-1:0] REQ_A;
  logic [NR*W-1:0] REQ_B;
  logic [NR-1:0]   REQ_READY;
  logic [NR-1:0]   RSLT_VALID;
  logic [2*W-1:0]  RSLT;
  logic            RSLT_LAST;
  logic            BUSY;

  mm_mult_arbiter #(.W_D(W), .NUM_REQ(NR), .MULT_DEPTH(6)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .HOLD       (HOLD),
    .REQ_VALID  (REQ_VALID),
    .REQ_LAST   (REQ_LAST),
    .REQ_A      (REQ_A),
    .REQ_B      (REQ_B),
    .REQ_READY  (REQ_READY),
    .RSLT_VALID (RSLT_VALID),
    .RSLT       (RSLT),
    .RSLT_LAST  (RSLT_LAST),
    .BUSY       (BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [NR-1:0]  tag;
    logic [2*W-1:0] prod;
    logic           last;
    int             due;
  } exp_t;

  exp_t           sb[$];
  int             due_list[$];
  int             owner_m = -1;
  int             next_m  = 0;
  int             checks  = 0;
  int             errors  = 0;
  int             cyc     = 0;
  bit             running = 1'b0;
  logic [W-1:0]   op_a [NR];
  logic [W-1:0]   op_b [NR];

  always @(posedge CLK) cyc <= cyc + 1;

  // Checks this cycle's handshake and BUSY against the model, then advances the model.
  task automatic checkOutput(input logic rst_n_i, input logic hold_i,
                             input logic [NR-1:0] valid_i, input logic [NR-1:0] last_i);
    logic [NR-1:0] exp_ready;
    logic          busy_exp;
    int            g;
    exp_t          e;
    exp_ready = '0;
    busy_exp  = 1'b0;
    g         = -1;
    if (rst_n_i) begin
      busy_exp = (owner_m >= 0);
      foreach (due_list[k]) if (due_list[k] >= cyc) busy_exp = 1'b1;
    end
    checks++;
    if (BUSY !== busy_exp) begin
      errors++;
      $display("[TB] FAIL busy cyc=%0d got=%b want=%b", cyc, BUSY, busy_exp);
    end
    if (rst_n_i && !hold_i) begin
      if (owner_m >= 0) g = owner_m;
      else begin
        for (int off = 0; off < NR; off++) begin
          int idx;
          idx = (next_m + off) % NR;
          if (valid_i[idx]) begin
            g = idx;
            break;
          end
        end
      end
      if (g >= 0) exp_ready[g] = 1'b1;
    end
    checks++;
    if (REQ_READY !== exp_ready) begin
      errors++;
      $display("[TB] FAIL ready cyc=%0d got=%b want=%b", cyc, REQ_READY, exp_ready);
    end
    if (!rst_n_i) begin
      owner_m = -1;
      next_m  = 0;
      sb.delete();
      due_list.delete();
    end else if (g >= 0 && valid_i[g]) begin
      e.tag     = '0;
      e.tag[g]  = 1'b1;
      e.prod    = 64'(op_a[g]) * 64'(op_b[g]);
      e.last    = last_i[g];
      e.due     = cyc + LAT;
      sb.push_back(e);
      due_list.push_back(e.due);
      if (last_i[g]) begin
        owner_m = -1;
        next_m  = (g + 1) % NR;
      end else begin
        owner_m = g;
      end
    end
    while (due_list.size() != 0 && due_list[0] < cyc) void'(due_list.pop_front());
  endtask

  task automatic applyStimulus(input logic rst_n_i, input logic hold_i,
                               input logic [NR-1:0] valid_i, input logic [NR-1:0] last_i);
    @(posedge CLK);
    #1;
    RST_N     = rst_n_i;
    HOLD      = hold_i;
    REQ_VALID = valid_i;
    REQ_LAST  = last_i;
    for (int i = 0; i < NR; i++) begin
      REQ_A[i*W +: W] = op_a[i];
      REQ_B[i*W +: W] = op_b[i];
    end
    running = 1'b1;
    @(negedge CLK);
    checkOutput(rst_n_i, hold_i, valid_i, last_i);
  endtask

  task automatic idleCycles(input int n);
    repeat (n) applyStimulus(1'b1, 1'b0, '0, '0);
  endtask

  // Result monitor: every returned product must match the oldest expectation on its due cycle.
  always @(negedge CLK) begin
    if (running) begin
      if (!RST_N) begin
        checks++;
        if (RSLT_VALID !== '0 || RSLT_LAST !== 1'b0) begin
          errors++;
          $display("[TB] FAIL reset_rslt cyc=%0d valid=%b last=%b want 0", cyc, RSLT_VALID, RSLT_LAST);
        end
      end else if (RSLT_VALID !== '0) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("[TB] FAIL spurious cyc=%0d valid=%b rslt=%h want none", cyc, RSLT_VALID, RSLT);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (RSLT_VALID !== e.tag || RSLT !== e.prod || RSLT_LAST !== e.last || cyc != e.due) begin
            errors++;
            $display("[TB] FAIL result cyc=%0d tag=%b want %b rslt=%h want %h last=%b want %b due=%0d",
                     cyc, RSLT_VALID, e.tag, RSLT, e.prod, RSLT_LAST, e.last, e.due);
          end
        end
      end else if (sb.size() != 0 && sb[0].due <= cyc) begin
        exp_t e;
        checks++;
        errors++;
        e = sb.pop_front();
        $display("[TB] FAIL missing cyc=%0d got valid=%b want tag=%b rslt=%h", cyc, RSLT_VALID, e.tag, e.prod);
      end
    end
  end

  initial begin
    RST_N     = 1'b0;
    HOLD      = 1'b0;
    REQ_VALID = '0;
    REQ_LAST  = '0;
    REQ_A     = '0;
    REQ_B     = '0;
    for (int i = 0; i < NR; i++) begin
      op_a[i] = 32'(i + 1);
      op_b[i] = 32'd7;
    end

    // Reset held with every requester asking
    repeat (4) applyStimulus(1'b0, 1'b0, 4'hF, 4'hF);

    // Single op from requester 0
    op_a[0] = 32'd3;
    op_b[0] = 32'd5;
    applyStimulus(1'b1, 1'b0, 4'b0001, 4'b0001);
    idleCycles(10);

    // Round robin from a fresh pointer
    applyStimulus(1'b0, 1'b0, '0, '0);
    for (int i = 0; i < NR; i++) begin
      op_a[i] = 32'(i + 1);
      op_b[i] = 32'd10;
    end
    repeat (5) applyStimulus(1'b1, 1'b0, 4'hF, 4'hF);
    idleCycles(10);

    // Burst lock: requester 1 holds the multiplier while requester 2 waits
    repeat (3) applyStimulus(1'b1, 1'b0, 4'b0110, 4'b0100);
    applyStimulus(1'b1, 1'b0, 4'b0110, 4'b0110);
    applyStimulus(1'b1, 1'b0, 4'b0100, 4'b0100);
    idleCycles(10);

    // HOLD in the middle of a burst from requester 2
    repeat (2) applyStimulus(1'b1, 1'b0, 4'b0100, 4'b0000);
    repeat (3) applyStimulus(1'b1, 1'b1, 4'b0100, 4'b0000);
    applyStimulus(1'b1, 1'b0, 4'b0000, 4'b0000);
    applyStimulus(1'b1, 1'b0, 4'b0100, 4'b0100);
    idleCycles(10);

    // Reset with five ops in flight, then a fresh op from requester 3
    repeat (5) applyStimulus(1'b1, 1'b0, 4'hF, 4'hF);
    applyStimulus(1'b0, 1'b0, 4'hF, 4'hF);
    op_a[3] = 32'd9;
    op_b[3] = 32'd11;
    applyStimulus(1'b1, 1'b0, 4'b1000, 4'b1000);
    idleCycles(10);
    applyStimulus(1'b1, 1'b0, 4'hF, 4'hF);
    idleCycles(10);

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      logic r_rst, r_hold;
      logic [NR-1:0] r_valid, r_last;
      for (int i = 0; i < NR; i++) begin
        op_a[i] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
        op_b[i] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
        r_last[i] = ($urandom_range(0, 2) == 0);
      end
      r_valid = NR'($urandom);
      r_rst   = ($urandom_range(0, 99) != 0);
      r_hold  = ($urandom_range(0, 7) == 0);
      applyStimulus(r_rst, r_hold, r_valid, r_last);
    end
    idleCycles(15);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain got=%0d pending want 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
